verificador_senha: RTL
======================

# verificador_senha

Parametrised, clocked password checker. Stores a programmed password, accepts user attempts through a valid strobe, and computes the absolute difference against the stored value, so negative differences no longer wrap. An attempt is accepted when the difference is within a configurable tolerance. Consecutive failures are counted, and the block locks out further attempts for a fixed number of cycles. It sits between the switch/key input logic and the LED/7-segment outputs of the lock panel.

## Interface
- WIDTH, 4: bit width of the password and of each attempt.
- TOL, 3: maximum accepted absolute difference (|senha − tentativa| ≤ TOL accepts).
- MAX_TENT, 3: consecutive failed attempts that trigger lockout (≥1).
- LOCK_CYCLES, 16: lockout duration in clock cycles (≥1).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- senha  in  WIDTH  password value to store.
- senha_load  in  1  store `senha` this cycle.
- tentativa  in  WIDTH  attempt value.
- tentativa_valid  in  1  evaluate `tentativa` this cycle.
- resp_valid  out  1  one-cycle pulse: result outputs updated.
- led_verde  out  1  last evaluated attempt accepted (held until next response).
- led_vermelho  out  1  last evaluated attempt rejected (held).
- igual / maior / menor  out  1 each  stored senha = / > / < last attempt (held).
- dif  out  WIDTH  |senha − tentativa| of last attempt, unsigned, no wrap (held).
- tentativas_rest  out  $clog2(MAX_TENT+1)  failures remaining before lockout.
- bloqueado  out  1  high while in lockout.
- programado  out  1  a password has been stored since reset.
- d  out  7  active-low 7-segment pattern (bit0 = a … bit6 = g) showing dif as a hex digit, saturated to F when dif > 15.

## Operation
- States: VAZIO (no password), ESPERA (ready), BLOQ (lockout). Reset → VAZIO.
- VAZIO:
  - senha_load stores senha, sets programado, and moves to ESPERA.
  - tentativa_valid is ignored: no resp_valid, outputs unchanged.
- ESPERA:
  - senha_load stores senha and restores tentativas_rest to MAX_TENT. Result outputs are unchanged.
  - tentativa_valid (without load) triggers an evaluation:
    - dif = senha ≥ tentativa ? senha − tentativa : tentativa − senha, computed at WIDTH bits.
    - igual, maior and menor are set from the unsigned comparison.
    - Accept (dif ≤ TOL): led_verde=1, led_vermelho=0, tentativas_rest=MAX_TENT.
    - Reject: led_verde=0, led_vermelho=1, tentativas_rest decrements.
    - If tentativas_rest reaches 0: enter BLOQ and load the lock counter with LOCK_CYCLES−1.
- Simultaneous senha_load and tentativa_valid in ESPERA: the load wins and the attempt is discarded with no resp_valid.
- BLOQ:
  - senha_load and tentativa_valid are both ignored.
  - The counter decrements each cycle. At 0, the block returns to ESPERA with tentativas_rest=MAX_TENT.
  - led_vermelho stays held.
- Back-to-back tentativa_valid on consecutive cycles: each one is evaluated independently (throughput 1/cycle).

## Timing
- Reset values:
  - resp_valid, led_verde, led_vermelho, igual, maior, menor, bloqueado and programado are 0.
  - dif=0, tentativas_rest=MAX_TENT, d=7'b1111111 (blank), stored password=0.
- Latency: tentativa_valid sampled at edge N → results and resp_valid visible after edge N (one-cycle registered latency). resp_valid is high for exactly one cycle.
- bloqueado rises at the same edge as the failing resp_valid that exhausts the attempts. It stays high for exactly LOCK_CYCLES cycles.
  - An attempt presented in the first cycle after bloqueado falls is evaluated.
- senha_load takes effect at the sampling edge. An attempt in the very next cycle compares against the new value.
- d is registered alongside dif and is also blank after reset until the first resp_valid.
- rst mid-lockout or mid-evaluation: the next cycle is the full reset state (VAZIO). The password must be reloaded.

## Test plan
- Reset, load senha=9, tentativa=7 → one cycle later: resp_valid=1, dif=2, led_verde=1, maior=1, tentativas_rest=3, d shows "2".
- senha=9, tentativa=14 → dif=5 (not 11), menor=1, led_vermelho=1, tentativas_rest=2.
- Tolerance boundary, senha=9:
  - tentativa=12 → dif=3, accepted.
  - tentativa=13 → dif=4, rejected.
  - tentativa=6 → dif=3, accepted, tentativas_rest restored to 3.
- Three rejects (tentativa=0, senha=9):
  - bloqueado=1 for 16 cycles; tentativa_valid=1 with tentativa=9 during that time → no resp_valid.
  - After lockout, tentativa=9 → accepted, igual=1, tentativas_rest=3.
- Before any load, tentativa_valid → no resp_valid, programado=0.
- Simultaneous load+attempt → password updated, no resp_valid.
- rst asserted at lockout cycle 5 → all outputs at reset values, state VAZIO.
- WIDTH=8, TOL=10: senha=200, tentativa=30 → dif=170, d shows "F", rejected.

Source files
------------

// File: rtl/verificador_senha_if.sv
// verificador_senha_if
// Groups the lock-panel signals of the password checker into one bundle.
// The master side (switch/key logic) drives the password, the attempt and
// their strobes. The slave side (the checker) returns the evaluation
// results, the lockout status and the 7-segment pattern.
//   senha / senha_load            : password value and its store strobe
//   tentativa / tentativa_valid   : attempt value and its evaluate strobe
//   resp_valid                    : one-cycle pulse, result outputs updated
//   led_verde / led_vermelho      : last attempt accepted / rejected
//   igual / maior / menor         : stored password =, >, < last attempt
//   dif                           : |senha - tentativa| of last attempt
//   tentativas_rest               : failures remaining before lockout
//   bloqueado / programado        : lockout active / password stored
//   d                             : active-low 7-segment pattern (bit0 = a)
interface verificador_senha_if #(
  parameter int WIDTH    = 4,
  parameter int MAX_TENT = 3
) ();
  localparam int RW = $clog2(MAX_TENT + 1);

  logic [WIDTH-1:0] senha;
  logic             senha_load;
  logic [WIDTH-1:0] tentativa;
  logic             tentativa_valid;
  logic             resp_valid;
  logic             led_verde;
  logic             led_vermelho;
  logic             igual;
  logic             maior;
  logic             menor;
  logic [WIDTH-1:0] dif;
  logic [RW-1:0]    tentativas_rest;
  logic             bloqueado;
  logic             programado;
  logic [6:0]       d;

  modport master (
    output senha, senha_load, tentativa, tentativa_valid,
    input  resp_valid, led_verde, led_vermelho, igual, maior, menor,
    input  dif, tentativas_rest, bloqueado, programado, d
  );

  modport slave (
    input  senha, senha_load, tentativa, tentativa_valid,
    output resp_valid, led_verde, led_vermelho, igual, maior, menor,
    output dif, tentativas_rest, bloqueado, programado, d
  );
endinterface

// File: rtl/verificador_senha.sv
// verificador_senha
// Clocked password checker for the lock panel. It stores a programmed
// password and evaluates each attempt by the absolute difference (no
// wrap-around). An attempt is accepted when the difference is within TOL.
// After MAX_TENT consecutive rejects the block locks for LOCK_CYCLES cycles
// and ignores every input. All outputs are registered.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset (back to "no password")
//   bus  : verificador_senha_if slave modport (see interface header)
module verificador_senha #(
  parameter int WIDTH       = 4,
  parameter int TOL         = 3,
  parameter int MAX_TENT    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  verificador_senha_if.slave bus
);

  localparam int RW = $clog2(MAX_TENT + 1);
  localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [RW-1:0] REST_MAX  = RW'(MAX_TENT);
  localparam logic [CW-1:0] LOCK_INIT = CW'(LOCK_CYCLES - 1);
  localparam logic [31:0]   TOL_U     = 32'(TOL);
  localparam logic [6:0]    SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    VAZIO  = 2'd0,
    ESPERA = 2'd1,
    BLOQ   = 2'd2
  } estado_t;

  // Hex digit to active-low segment pattern, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7_n(input logic [3:0] v);
    logic [6:0] on;
    case (v)
      4'h0:    on = 7'h3F;
      4'h1:    on = 7'h06;
      4'h2:    on = 7'h5B;
      4'h3:    on = 7'h4F;
      4'h4:    on = 7'h66;
      4'h5:    on = 7'h6D;
      4'h6:    on = 7'h7D;
      4'h7:    on = 7'h07;
      4'h8:    on = 7'h7F;
      4'h9:    on = 7'h6F;
      4'hA:    on = 7'h77;
      4'hB:    on = 7'h7C;
      4'hC:    on = 7'h39;
      4'hD:    on = 7'h5E;
      4'hE:    on = 7'h79;
      4'hF:    on = 7'h71;
      default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  // Registered state
  estado_t          estado_r;
  logic [WIDTH-1:0] senha_r;
  logic [RW-1:0]    rest_r;
  logic [CW-1:0]    cnt_r;
  logic             resp_r;
  logic             verde_r;
  logic             verm_r;
  logic             igual_r;
  logic             maior_r;
  logic             menor_r;
  logic [WIDTH-1:0] dif_r;
  logic [6:0]       d_r;
  logic             bloq_r;
  logic             prog_r;

  // Next-state values
  estado_t          estado_nxt_s;
  logic [WIDTH-1:0] senha_nxt_s;
  logic [RW-1:0]    rest_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             resp_nxt_s;
  logic             verde_nxt_s;
  logic             verm_nxt_s;
  logic             igual_nxt_s;
  logic             maior_nxt_s;
  logic             menor_nxt_s;
  logic [WIDTH-1:0] dif_nxt_s;
  logic [6:0]       d_nxt_s;
  logic             bloq_nxt_s;
  logic             prog_nxt_s;

  // Evaluation datapath (always computed, used only when an attempt is taken)
  logic             ge_s;
  logic [WIDTH-1:0] dif_s;
  logic [31:0]      dif_ext_s;
  logic [3:0]       nib_s;
  logic             aceita_s;

  // Subtract in the direction that keeps the result non-negative.
  assign ge_s      = (senha_r >= bus.tentativa);
  assign dif_s     = ge_s ? (senha_r - bus.tentativa) : (bus.tentativa - senha_r);
  assign dif_ext_s = 32'(dif_s);
  assign aceita_s  = (dif_ext_s <= TOL_U);
  // A single hex digit cannot show more than F, so larger values saturate.
  assign nib_s     = (dif_ext_s > 32'd15) ? 4'hF : dif_ext_s[3:0];

  // Next-state and output computation for the checker FSM.
  always_comb begin
    estado_nxt_s = estado_r;
    senha_nxt_s  = senha_r;
    rest_nxt_s   = rest_r;
    cnt_nxt_s    = cnt_r;
    resp_nxt_s   = 1'b0;
    verde_nxt_s  = verde_r;
    verm_nxt_s   = verm_r;
    igual_nxt_s  = igual_r;
    maior_nxt_s  = maior_r;
    menor_nxt_s  = menor_r;
    dif_nxt_s    = dif_r;
    d_nxt_s      = d_r;
    bloq_nxt_s   = bloq_r;
    prog_nxt_s   = prog_r;

    case (estado_r)
      VAZIO: begin
        // Attempts are meaningless until a password exists.
        if (bus.senha_load) begin
          senha_nxt_s  = bus.senha;
          prog_nxt_s   = 1'b1;
          rest_nxt_s   = REST_MAX;
          estado_nxt_s = ESPERA;
        end else begin
          estado_nxt_s = VAZIO;
        end
      end

      ESPERA: begin
        if (bus.senha_load) begin
          // A new password wins over a simultaneous attempt and forgives
          // earlier failures.
          senha_nxt_s = bus.senha;
          rest_nxt_s  = REST_MAX;
        end else if (bus.tentativa_valid) begin
          resp_nxt_s  = 1'b1;
          dif_nxt_s   = dif_s;
          d_nxt_s     = seg7_n(nib_s);
          igual_nxt_s = (senha_r == bus.tentativa);
          maior_nxt_s = (senha_r > bus.tentativa);
          menor_nxt_s = (senha_r < bus.tentativa);
          if (aceita_s) begin
            verde_nxt_s = 1'b1;
            verm_nxt_s  = 1'b0;
            rest_nxt_s  = REST_MAX;
          end else begin
            verde_nxt_s = 1'b0;
            verm_nxt_s  = 1'b1;
            if (rest_r <= RW'(1)) begin
              // Last allowed failure: lock out with the counter preloaded so
              // bloqueado stays high for exactly LOCK_CYCLES cycles.
              rest_nxt_s   = '0;
              cnt_nxt_s    = LOCK_INIT;
              bloq_nxt_s   = 1'b1;
              estado_nxt_s = BLOQ;
            end else begin
              rest_nxt_s = rest_r - RW'(1);
            end
          end
        end else begin
          estado_nxt_s = ESPERA;
        end
      end

      BLOQ: begin
        // Inputs ignored; result outputs keep the rejecting attempt.
        if (cnt_r == '0) begin
          rest_nxt_s   = REST_MAX;
          bloq_nxt_s   = 1'b0;
          estado_nxt_s = ESPERA;
        end else begin
          cnt_nxt_s = cnt_r - CW'(1);
        end
      end

      default: begin
        estado_nxt_s = VAZIO;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_r <= VAZIO;
      senha_r  <= '0;
      rest_r   <= REST_MAX;
      cnt_r    <= '0;
      resp_r   <= 1'b0;
      verde_r  <= 1'b0;
      verm_r   <= 1'b0;
      igual_r  <= 1'b0;
      maior_r  <= 1'b0;
      menor_r  <= 1'b0;
      dif_r    <= '0;
      d_r      <= SEG_BLANK;
      bloq_r   <= 1'b0;
      prog_r   <= 1'b0;
    end else begin
      estado_r <= estado_nxt_s;
      senha_r  <= senha_nxt_s;
      rest_r   <= rest_nxt_s;
      cnt_r    <= cnt_nxt_s;
      resp_r   <= resp_nxt_s;
      verde_r  <= verde_nxt_s;
      verm_r   <= verm_nxt_s;
      igual_r  <= igual_nxt_s;
      maior_r  <= maior_nxt_s;
      menor_r  <= menor_nxt_s;
      dif_r    <= dif_nxt_s;
      d_r      <= d_nxt_s;
      bloq_r   <= bloq_nxt_s;
      prog_r   <= prog_nxt_s;
    end
  end

  assign bus.resp_valid      = resp_r;
  assign bus.led_verde       = verde_r;
  assign bus.led_vermelho    = verm_r;
  assign bus.igual           = igual_r;
  assign bus.maior           = maior_r;
  assign bus.menor           = menor_r;
  assign bus.dif             = dif_r;
  assign bus.tentativas_rest = rest_r;
  assign bus.bloqueado       = bloq_r;
  assign bus.programado      = prog_r;
  assign bus.d               = d_r;

endmodule
